// File: rtl/uart_line_echo_pkg.sv
// Shared types and constants for the UART line echo block.
package uart_echo_pkg;

    typedef enum logic [2:0] {
        COLLECT   = 3'd0,
        SEND_BODY = 3'd1,
        SEND_Q    = 3'd2,
        SEND_CR   = 3'd3,
        SEND_LF   = 3'd4
    } state_t;

    localparam logic [7:0] ASC_CR = 8'h0D;
    localparam logic [7:0] ASC_LF = 8'h0A;
    localparam logic [7:0] ASC_Q  = 8'h3F;

    // True for bytes that are stored in the line buffer.
    function automatic logic is_payload(input logic [7:0] b);
        return (b != ASC_CR) && (b != ASC_LF);
    endfunction

endpackage

// File: rtl/uart_line_echo_if.sv
// Byte stream with error flag and valid/ready handshake.
interface uart_line_echo_if;
    logic [7:0] data;
    logic       error;
    logic       valid;
    logic       ready;

    modport master (output data, output error, output valid, input ready);
    modport slave  (input data, input error, input valid, output ready);
endinterface

// File: rtl/uart_line_echo_ram.sv
// Line buffer: synchronous write, asynchronous read.
module line_buffer_ram #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 6
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_line_echo.sv
// Collects a received line until CR, then echoes it (or "?" on error) followed by CR LF.
module uart_line_echo
    import uart_echo_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 6,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    uart_line_echo_if.slave  from_uart,
    uart_line_echo_if.master to_uart,
    output logic [CNT_W-1:0] lines_echoed,
    output logic [CNT_W-1:0] lines_bad,
    output logic             overflow
);

    localparam int unsigned CW = AW + 1;

    state_t        state;
    logic [CW-1:0] count;
    logic [AW-1:0] rd_ptr;
    logic          line_err;
    logic          accept;
    logic          wr_en;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic [7:0]    tx_data;
    logic          tx_valid;

    assign from_uart.ready = (state == COLLECT) && reset;
    assign accept          = from_uart.valid && from_uart.ready;
    assign wr_en           = accept && !from_uart.error && is_payload(from_uart.data)
                             && (count < CW'(DEPTH));
    // Address 0 is needed on the CR edge; the next byte is needed on each body transfer.
    assign rd_addr         = (state == SEND_BODY) ? rd_ptr + AW'(1) : '0;

    assign to_uart.data  = tx_data;
    assign to_uart.valid = tx_valid;
    assign to_uart.error = 1'b0;

    line_buffer_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (count[AW-1:0]),
        .wr_data (from_uart.data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= COLLECT;
            count        <= '0;
            rd_ptr       <= '0;
            line_err     <= 1'b0;
            tx_valid     <= 1'b0;
            tx_data      <= '0;
            lines_echoed <= '0;
            lines_bad    <= '0;
            overflow     <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (accept) begin
                        if (from_uart.error) begin
                            line_err <= 1'b1;
                        end else if (from_uart.data == ASC_CR) begin
                            tx_valid <= 1'b1;
                            if (line_err) begin
                                state   <= SEND_Q;
                                tx_data <= ASC_Q;
                            end else if (count == '0) begin
                                state   <= SEND_CR;
                                tx_data <= ASC_CR;
                            end else begin
                                state   <= SEND_BODY;
                                tx_data <= rd_data;
                            end
                        end else if (from_uart.data == ASC_LF) begin
                            count <= count;
                        end else if (count < CW'(DEPTH)) begin
                            count <= count + CW'(1);
                        end else begin
                            overflow <= 1'b1;
                        end
                    end
                end
                SEND_BODY: begin
                    if (to_uart.ready) begin
                        if ({1'b0, rd_ptr} == count - CW'(1)) begin
                            state   <= SEND_CR;
                            tx_data <= ASC_CR;
                        end else begin
                            rd_ptr  <= rd_ptr + AW'(1);
                            tx_data <= rd_data;
                        end
                    end
                end
                SEND_Q: begin
                    if (to_uart.ready) begin
                        state   <= SEND_CR;
                        tx_data <= ASC_CR;
                    end
                end
                SEND_CR: begin
                    if (to_uart.ready) begin
                        state   <= SEND_LF;
                        tx_data <= ASC_LF;
                    end
                end
                SEND_LF: begin
                    if (to_uart.ready) begin
                        state        <= COLLECT;
                        tx_valid     <= 1'b0;
                        lines_echoed <= lines_echoed + CNT_W'(1);
                        lines_bad    <= lines_bad + CNT_W'(line_err);
                        count        <= '0;
                        rd_ptr       <= '0;
                        line_err     <= 1'b0;
                    end
                end
                default: begin
                    state    <= COLLECT;
                    tx_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_line_echo.sv
// Scoreboard bench for uart_line_echo: directed lines in, expected echo bytes queued and checked.
module tb_uart_line_echo;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] lines_echoed;
    logic [15:0] lines_bad;
    logic        overflow;

    uart_line_echo_if from_uart ();
    uart_line_echo_if to_uart ();

    uart_line_echo #(.DEPTH(64), .AW(6), .CNT_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .from_uart    (from_uart),
        .to_uart      (to_uart),
        .lines_echoed (lines_echoed),
        .lines_bad    (lines_bad),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    // Drive one byte at a negedge and return at the negedge after it was accepted.
    task automatic send(input logic [7:0] b, input logic e);
        int n = 0;
        from_uart.data  = b;
        from_uart.error = e;
        from_uart.valid = 1'b1;
        while (!from_uart.ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: byte 0x%0h never accepted", b);
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
        from_uart.valid = 1'b0;
        from_uart.error = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i], 1'b0);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || to_uart.valid) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: %0d bytes still expected", exp_q.size());
        end
    endtask

    task automatic set_tx_ready(input logic r);
        @(posedge clk);
        #1 to_uart.ready = r;
    endtask

    // Monitor: pops the scoreboard on each transfer and checks data hold under stall.
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = '0;

    always @(negedge clk) begin
        if (prev_stall && to_uart.valid) check("tx_hold", 32'(to_uart.data), 32'(prev_data));
        if (to_uart.valid && to_uart.ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_tx: got 0x%0h expected nothing", to_uart.data);
            end else begin
                check("tx_byte", 32'(to_uart.data), 32'(exp_q.pop_front()));
            end
        end
        prev_stall = to_uart.valid && !to_uart.ready;
        prev_data  = to_uart.data;
    end

    initial begin
        reset           = 1'b0;
        from_uart.data  = '0;
        from_uart.error = 1'b0;
        from_uart.valid = 1'b0;
        to_uart.ready   = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_from_ready", 32'(from_uart.ready), 32'd0);
        check("rst_tx_valid", 32'(to_uart.valid), 32'd0);
        check("rst_tx_data", 32'(to_uart.data), 32'd0);
        check("rst_tx_error", 32'(to_uart.error), 32'd0);
        check("rst_echoed", 32'(lines_echoed), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("from_ready_after_rst", 32'(from_uart.ready), 32'd1);

        // "AB" CR
        push_str("AB");
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
        send_str("AB");
        send(8'h0D, 1'b0);
        check("ab_first_valid", 32'(to_uart.valid), 32'd1);
        check("ab_first_data", 32'(to_uart.data), 32'h41);
        check("ab_from_ready_busy", 32'(from_uart.ready), 32'd0);
        drain();
        check("ab_echoed", 32'(lines_echoed), 32'd1);
        check("ab_bad", 32'(lines_bad), 32'd0);

        // Empty line
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
        send(8'h0D, 1'b0);
        check("empty_first_data", 32'(to_uart.data), 32'h0D);
        drain();
        check("empty_echoed", 32'(lines_echoed), 32'd2);
        check("empty_bad", 32'(lines_bad), 32'd0);

        // Error line, then a clean line
        exp_q.push_back(8'h3F);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
        send(8'h58, 1'b0);
        send(8'h99, 1'b1);
        send(8'h59, 1'b0);
        send(8'h0D, 1'b0);
        drain();
        check("err_echoed", 32'(lines_echoed), 32'd3);
        check("err_bad", 32'(lines_bad), 32'd1);
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
        send(8'h5A, 1'b0);
        send(8'h0D, 1'b0);
        drain();
        check("z_echoed", 32'(lines_echoed), 32'd4);
        check("z_bad", 32'(lines_bad), 32'd1);
        check("pre_ovf", 32'(overflow), 32'd0);

        // Overflow: 70 bytes, only 0x30..0x6F survive
        for (int i = 0; i < 64; i++) exp_q.push_back(8'(8'h30 + i));
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
        for (int i = 0; i < 70; i++) send(8'(8'h30 + i), 1'b0);
        check("ovf_set", 32'(overflow), 32'd1);
        send(8'h0D, 1'b0);
        drain();
        check("ovf_echoed", 32'(lines_echoed), 32'd5);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Back-pressure with an embedded LF
        set_tx_ready(1'b0);
        push_str("abcd");
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
        send_str("abc");
        send(8'h0A, 1'b0);
        send(8'h64, 1'b0);
        send(8'h0D, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp_from_ready", 32'(from_uart.ready), 32'd0);
        end
        check("bp_valid", 32'(to_uart.valid), 32'd1);
        check("bp_data", 32'(to_uart.data), 32'h61);
        set_tx_ready(1'b1);
        set_tx_ready(1'b1);
        set_tx_ready(1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp_mid_from_ready", 32'(from_uart.ready), 32'd0);
        end
        check("bp_mid_data", 32'(to_uart.data), 32'h63);
        set_tx_ready(1'b1);
        drain();
        check("bp_echoed", 32'(lines_echoed), 32'd6);

        // Reset during SEND_BODY
        set_tx_ready(1'b0);
        @(negedge clk);
        send_str("PQR");
        send(8'h0D, 1'b0);
        check("rst_mid_valid_before", 32'(to_uart.valid), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_valid", 32'(to_uart.valid), 32'd0);
        check("rst_mid_echoed", 32'(lines_echoed), 32'd0);
        check("rst_mid_bad", 32'(lines_bad), 32'd0);
        check("rst_mid_ovf", 32'(overflow), 32'd0);
        check("rst_mid_from_ready", 32'(from_uart.ready), 32'd0);
        set_tx_ready(1'b1);
        repeat (3) @(negedge clk);
        check("rst_mid_no_resume", 32'(to_uart.valid), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("rst_rel_from_ready", 32'(from_uart.ready), 32'd1);
        push_str("OK");
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
        send_str("OK");
        send(8'h0D, 1'b0);
        drain();
        check("rst_rel_echoed", 32'(lines_echoed), 32'd1);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
